// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron of a hidden layer, then streams them in index order.
// Optional argmax readout is compiled in when LAYER_ARGMAX_EN is defined.
module layer_out_serializer #(
   parameter int NUM_NEURONS = 30,
   parameter int DATA_WIDTH  = 16,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
   input  logic [NUM_NEURONS-1:0]            neuron_valid,
   output logic [DATA_WIDTH-1:0]             s_data,
   output logic                              s_valid,
   input  logic                              s_ready,
   output logic                              s_last,
   output logic                              busy,
   output logic                              err,
   output logic [IDX_W-1:0]                  class_idx,
   output logic                              class_valid
);

   // Stream handshake: a word moves when s_valid && s_ready are both high at a rising
   // clk edge; while s_ready is low, s_data and s_last hold their value.
   typedef enum logic [1:0] {IDLE, COLLECT, STREAM} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   state_t                  state_q, state_d;
   logic [NUM_NEURONS-1:0]  mask_q, mask_d;
   logic [DATA_WIDTH-1:0]   word_q [NUM_NEURONS];
   logic [DATA_WIDTH-1:0]   word_d [NUM_NEURONS];
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    err_q, err_d;
   logic                    xfer;
   logic                    at_last;

   assign s_valid = (state_q == STREAM);
   assign busy    = (state_q != IDLE);
   assign at_last = (idx_q == LAST_IDX);
   assign s_last  = s_valid && at_last;
   assign s_data  = word_q[idx_q];
   assign err     = err_q;
   assign xfer    = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      word_d  = word_q;
      idx_d   = idx_q;
      err_d   = err_q;
      case (state_q)
         IDLE, COLLECT: begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
               if (neuron_valid[i]) begin
                  word_d[i] = neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
                  mask_d[i] = 1'b1;
                  if (mask_q[i]) err_d = 1'b1;
               end
            end
            if (state_q == IDLE) begin
               if (|neuron_valid) state_d = COLLECT;
            end else if (&mask_q) begin
               // Full-mask test uses the registered mask, costing one cycle of latency.
               state_d = STREAM;
               idx_d   = '0;
            end
         end
         STREAM: begin
            if (|neuron_valid) err_d = 1'b1;
            if (xfer) begin
               if (at_last) begin
                  state_d = IDLE;
                  mask_d  = '0;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) word_q[i] <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         word_q  <= word_d;
      end
   end

`ifdef LAYER_ARGMAX_EN
   logic [DATA_WIDTH-1:0] max_q, max_d;
   logic [IDX_W-1:0]      max_idx_q, max_idx_d;
   logic [IDX_W-1:0]      class_idx_q, class_idx_d;
   logic                  class_valid_q, class_valid_d;
   logic                  take;

   // Strictly-greater replacement keeps the lowest index on ties.
   assign take = (idx_q == '0) || (s_data > max_q);

   always_comb begin
      max_d         = max_q;
      max_idx_d     = max_idx_q;
      class_idx_d   = class_idx_q;
      class_valid_d = 1'b0;
      if (xfer && take) begin
         max_d     = s_data;
         max_idx_d = idx_q;
      end
      if (xfer && at_last) begin
         class_valid_d = 1'b1;
         class_idx_d   = take ? idx_q : max_idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         max_q         <= '0;
         max_idx_q     <= '0;
         class_idx_q   <= '0;
         class_valid_q <= 1'b0;
      end else begin
         max_q         <= max_d;
         max_idx_q     <= max_idx_d;
         class_idx_q   <= class_idx_d;
         class_valid_q <= class_valid_d;
      end
   end

   assign class_idx   = class_idx_q;
   assign class_valid = class_valid_q;
`else
   assign class_idx   = '0;
   assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer with a 4-neuron layer; follows LAYER_ARGMAX_EN.
module tb_layer_out_serializer;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;
`ifdef LAYER_ARGMAX_EN
   localparam bit ARGMAX = 1'b1;
`else
   localparam bit ARGMAX = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] neuron_out;
   logic [N-1:0]   neuron_valid;
   logic [W-1:0]   s_data;
   logic           s_valid;
   logic           s_ready;
   logic           s_last;
   logic           busy;
   logic           err;
   logic [IW-1:0]  class_idx;
   logic           class_valid;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: what each neuron reported, which have reported, sticky error
   logic [W-1:0]   model_buf [N];
   logic [N-1:0]   model_mask;
   logic           model_err;
   logic [IW-1:0]  last_class;
   logic [W-1:0]   exp_q [$];
   logic [N*W-1:0] rwords;
   logic [N-1:0]   rvm;

   always #5 clk = ~clk;

   layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .busy(busy), .err(err), .class_idx(class_idx), .class_valid(class_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*W-1:0] rep(input logic [W-1:0] w);
      return {N{w}};
   endfunction

   task automatic model_reset();
      model_mask = '0;
      model_err  = 1'b0;
      last_class = '0;
      for (int i = 0; i < N; i++) model_buf[i] = '0;
   endtask

   // Holds rst for one cycle, then checks every output against its reset value.
   task automatic reset_dut();
      rst = 1'b1;
      neuron_valid = '0;
      s_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("rst.s_valid", s_valid, 0);
      chk("rst.s_last", s_last, 0);
      chk("rst.busy", busy, 0);
      chk("rst.err", err, 0);
      chk("rst.class_idx", class_idx, 0);
      chk("rst.class_valid", class_valid, 0);
      chk("rst.s_data", s_data, 0);
   endtask

   task automatic capture(input logic [N-1:0] vm, input logic [N*W-1:0] words);
      neuron_valid = vm;
      neuron_out   = words;
      for (int i = 0; i < N; i++) begin
         if (vm[i]) begin
            if (model_mask[i]) model_err = 1'b1;
            model_buf[i]  = words[i*W +: W];
            model_mask[i] = 1'b1;
         end
      end
      @(negedge clk);
      neuron_valid = '0;
      neuron_out   = {$urandom, $urandom};
      chk("cap.busy", busy, 1);
      chk("cap.err", err, model_err);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("gap.busy", busy, 1);
         chk("gap.s_valid", s_valid, 0);
      end
   endtask

   // Called right after the final capture: the mask-register cycle shows no s_valid yet.
   task automatic await_stream();
      chk("lat.s_valid_early", s_valid, 0);
      chk("lat.busy", busy, 1);
      @(negedge clk);
   endtask

   task automatic run_stream(input logic [31:0] rdy_pat, input int pat_len, input bit rand_rdy,
                             input int stray_at, input int max_xfers);
      int           xfers;
      int           want;
      logic         r;
      logic [W-1:0] best;
      logic [IW-1:0] best_i;
      xfers = 0;
      want  = (max_xfers < N) ? max_xfers : N;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(model_buf[i]);
      best   = model_buf[0];
      best_i = '0;
      for (int i = 1; i < N; i++) begin
         if (model_buf[i] > best) begin
            best   = model_buf[i];
            best_i = IW'(i);
         end
      end
      for (int cyc = 0; cyc < 200 && exp_q.size() > 0 && xfers < max_xfers; cyc++) begin
         r = (cyc < pat_len) ? rdy_pat[cyc] : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
         s_ready = r;
         if (cyc == stray_at) begin
            neuron_valid = 4'b0100;
            neuron_out   = rep(16'hDEAD);
            model_err    = 1'b1;
         end else begin
            neuron_valid = '0;
         end
         chk("str.s_valid", s_valid, 1);
         chk("str.busy", busy, 1);
         chk("str.s_data", s_data, exp_q[0]);
         chk("str.s_last", s_last, exp_q.size() == 1);
         if (r) begin
            void'(exp_q.pop_front());
            xfers++;
         end
         @(negedge clk);
      end
      neuron_valid = '0;
      s_ready = 1'b0;
      chk("str.xfers", xfers, want);
      if (exp_q.size() == 0) begin
         if (ARGMAX) last_class = best_i;
         model_mask = '0;
         chk("end.s_valid", s_valid, 0);
         chk("end.busy", busy, 0);
         chk("end.err", err, model_err);
         chk("end.class_valid", class_valid, ARGMAX);
         chk("end.class_idx", class_idx, last_class);
         @(negedge clk);
         chk("end.class_valid_drop", class_valid, 0);
         chk("end.class_idx_hold", class_idx, last_class);
      end
   endtask

   initial begin
      rst = 1'b1;
      neuron_valid = '0;
      neuron_out = '0;
      s_ready = 1'b0;
      model_reset();
      @(negedge clk);
      reset_dut();

      // one-hot captures on separate cycles, continuous ready
      capture(4'b0001, rep(16'h0100));
      capture(4'b0010, rep(16'h0A00));
      capture(4'b0100, rep(16'h0300));
      capture(4'b1000, rep(16'h0200));
      await_stream();
      run_stream(32'h0, 0, 1'b0, -1, N);

      // all neurons in one cycle, ties on the maximum
      capture(4'b1111, {16'd5, 16'd2, 16'd5, 16'd5});
      await_stream();
      run_stream(32'h0, 0, 1'b0, -1, N);

      // back-pressure pattern 1,0,0,1,1,0,1
      capture(4'b0011, {16'h0, 16'h0, 16'h1234, 16'h00FF});
      gap(1);
      capture(4'b1100, {16'h7777, 16'h8001, 16'h0, 16'h0});
      await_stream();
      run_stream(32'b1011001, 7, 1'b0, -1, N);

      // duplicate capture, then a stray pulse while streaming
      capture(4'b0100, rep(16'h0011));
      capture(4'b0100, rep(16'h0022));
      capture(4'b0001, rep(16'h0007));
      capture(4'b1010, rep(16'h0009));
      await_stream();
      run_stream(32'h0, 0, 1'b0, 1, N);

      // reset mid-collection and mid-stream, then a clean collection
      capture(4'b0001, rep(16'h0AAA));
      capture(4'b1000, rep(16'h0BBB));
      reset_dut();
      capture(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
      await_stream();
      run_stream(32'h0, 0, 1'b0, -1, 2);
      reset_dut();
      capture(4'b0110, {16'h0, 16'h0C00, 16'h0D00, 16'h0});
      capture(4'b1001, {16'h0E00, 16'h0, 16'h0, 16'h0F00});
      await_stream();
      run_stream(32'h0, 0, 1'b0, -1, N);

      // randomized collections with random grouping, gaps and back-pressure
      for (int it = 0; it < 8; it++) begin
         while (model_mask != 4'b1111) begin
            rvm = 4'($urandom_range(1, 15)) & ~model_mask;
            if (rvm != '0) begin
               for (int i = 0; i < N; i++)
                  rwords[i*W +: W] = (it % 2 == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
               capture(rvm, rwords);
               if (model_mask != 4'b1111) gap($urandom_range(0, 2));
            end
         end
         await_stream();
         run_stream(32'h0, 0, 1'b1, -1, N);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
